// File: rtl/ahbl_sram_excl.sv
// AHB-Lite SRAM slave with a single-granule exclusive-access monitor.
// Each in-range data phase takes N_WAIT wait states. Out-of-range addresses get a 2-cycle ERROR response.
module ahbl_sram_excl #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32,
   parameter int DEPTH  = 1024,
   parameter int N_WAIT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ahbls_hready,
   output logic              ahbls_hready_resp,
   output logic              ahbls_hresp,
   output logic              ahbls_hexokay,
   input  logic [W_ADDR-1:0] ahbls_haddr,
   input  logic              ahbls_hwrite,
   input  logic [1:0]        ahbls_htrans,
   input  logic              ahbls_hsel,
   input  logic [2:0]        ahbls_hsize,
   input  logic              ahbls_hexcl,
   input  logic [W_DATA-1:0] ahbls_hwdata,
   output logic [W_DATA-1:0] ahbls_hrdata
);
   localparam int unsigned NB  = W_DATA / 8;
   localparam int unsigned OFF = $clog2(NB);
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam logic [2:0]  WAIT_LAST = 3'(N_WAIT > 0 ? N_WAIT - 1 : 0);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

   state_t            state_q, state_d;
   logic [2:0]        wcnt_q, wcnt_d;
   logic [AW-1:0]     addr_q;
   logic [OFF-1:0]    off_q;
   logic [2:0]        size_q;
   logic              write_q, excl_q;
   logic              resv_vld_q, resv_vld_d;
   logic [AW-1:0]     resv_addr_q, resv_addr_d;
   logic [W_DATA-1:0] mem_q [DEPTH];

   logic              accept, in_range, complete, excl_match, commit;
   logic [NB-1:0]     lane_en;
   logic              unused;

   assign unused = ahbls_htrans[0];

   // Also gated on our own HREADYOUT so a malformed master cannot restart a stalled phase.
   assign accept   = ahbls_hsel & ahbls_htrans[1] & ahbls_hready & ahbls_hready_resp;
   assign in_range = (ahbls_haddr >> (AW + OFF)) == '0;

   assign ahbls_hready_resp = !(state_q inside {S_WAIT, S_ERR1});
   assign ahbls_hresp       = state_q inside {S_ERR1, S_ERR2};

   assign complete   = (state_q == S_DONE);
   assign excl_match = resv_vld_q && (resv_addr_q == addr_q);
   assign commit     = complete && write_q && (!excl_q || excl_match);

   assign ahbls_hexokay = complete && excl_q && (!write_q || excl_match);
   assign ahbls_hrdata  = ((state_q inside {S_WAIT, S_DONE}) && !write_q) ? mem_q[addr_q] : '0;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         S_WAIT: begin
            wcnt_d = wcnt_q + 3'd1;
            if (wcnt_q == WAIT_LAST) state_d = S_DONE;
         end
         S_ERR1:  state_d = S_ERR2;
         default: ;
      endcase
      if (accept) begin
         wcnt_d = '0;
         if (!in_range)       state_d = S_ERR1;
         else if (N_WAIT > 0) state_d = S_WAIT;
         else                 state_d = S_DONE;
      end else if (ahbls_hready_resp) begin
         state_d = S_IDLE;
      end
   end

   always_comb begin
      resv_vld_d  = resv_vld_q;
      resv_addr_d = resv_addr_q;
      if (complete) begin
         if (excl_q && !write_q) begin
            resv_vld_d  = 1'b1;
            resv_addr_d = addr_q;
         end else if (write_q && (excl_q || excl_match)) begin
            resv_vld_d = 1'b0;
         end
      end
   end

   // A lane is written when it lies in the same size-aligned block as the byte offset.
   always_comb begin
      lane_en = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         logic [OFF-1:0] lane;
         lane       = i[OFF-1:0];
         lane_en[i] = (lane >> size_q) == (off_q >> size_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wcnt_q      <= '0;
         addr_q      <= '0;
         off_q       <= '0;
         size_q      <= '0;
         write_q     <= 1'b0;
         excl_q      <= 1'b0;
         resv_vld_q  <= 1'b0;
         resv_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         resv_vld_q  <= resv_vld_d;
         resv_addr_q <= resv_addr_d;
         if (accept) begin
            addr_q  <= ahbls_haddr[AW+OFF-1:OFF];
            off_q   <= ahbls_haddr[OFF-1:0];
            size_q  <= ahbls_hsize;
            write_q <= ahbls_hwrite;
            excl_q  <= ahbls_hexcl;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (lane_en[i]) mem_q[addr_q][8*i +: 8] <= ahbls_hwdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ahbl_sram_excl.sv
// Scoreboard bench for ahbl_sram_excl: a reference model queues the expected response of each transfer
// as it is issued, and a negedge monitor checks every data phase and every idle cycle.
module tb_ahbl_sram_excl;
   localparam int unsigned NW        = 2;
   localparam logic [31:0] MEM_BYTES = 32'h1000;
   localparam logic [1:0]  T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        hready_resp, hresp, hexokay;
   logic [31:0] haddr = '0, hwdata = '0, hrdata;
   logic        hwrite = 1'b0, hsel = 1'b0, hexcl = 1'b0;
   logic [1:0]  htrans = T_IDLE;
   logic [2:0]  hsize = '0;

   typedef struct {
      logic        err;
      logic        exok;
      logic [31:0] rdata;
      int unsigned waits;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   logic [31:0] ref_mem [int unsigned];
   logic        ref_vld  = 1'b0;
   int unsigned ref_word = 0;
   int unsigned n_chk = 0, n_pass = 0;

   logic        dphase = 1'b0, resp_or = 1'b0, resp_and = 1'b1, exok_or = 1'b0, wait_ok;
   int unsigned wcnt = 0;

   always #5 clk = ~clk;

   ahbl_sram_excl #(
      .W_ADDR(32),
      .W_DATA(32),
      .DEPTH (1024),
      .N_WAIT(NW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ahbls_hready     (hready_resp),
      .ahbls_hready_resp(hready_resp),
      .ahbls_hresp      (hresp),
      .ahbls_hexokay    (hexokay),
      .ahbls_haddr      (haddr),
      .ahbls_hwrite     (hwrite),
      .ahbls_htrans     (htrans),
      .ahbls_hsel       (hsel),
      .ahbls_hsize      (hsize),
      .ahbls_hexcl      (hexcl),
      .ahbls_hwdata     (hwdata),
      .ahbls_hrdata     (hrdata)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
   endtask

   function automatic exp_t model(input logic w, input logic ex, input logic [31:0] a,
                                  input logic [2:0] sz, input logic [31:0] wd);
      exp_t        e;
      int unsigned wi   = a >> 2;
      int unsigned nb   = 1 << sz;
      int unsigned base = (a & 3) & ~(nb - 1);
      logic        ok;
      logic [31:0] m;
      e.err = 1'b0; e.exok = 1'b0; e.rdata = '0; e.waits = NW;
      if (a >= MEM_BYTES) begin
         e.err   = 1'b1;
         e.waits = 1;
         return e;
      end
      if (!w) begin
         e.rdata = ref_mem.exists(wi) ? ref_mem[wi] : 32'hx;
         if (ex) begin
            e.exok   = 1'b1;
            ref_vld  = 1'b1;
            ref_word = wi;
         end
      end else begin
         ok     = !ex || (ref_vld && ref_word == wi);
         e.exok = ex && ok;
         if (ok) begin
            m = ref_mem.exists(wi) ? ref_mem[wi] : '0;
            for (int unsigned b = base; b < base + nb; b++) m[8*b +: 8] = wd[8*b +: 8];
            ref_mem[wi] = m;
            if (ref_vld && ref_word == wi) ref_vld = 1'b0;
         end
         if (ex) ref_vld = 1'b0;
      end
      return e;
   endfunction

   // Called at posedge+1; returns at posedge+1 of the transfer's first data-phase cycle.
   task automatic addr_phase(input logic w, input logic ex, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd, input logic [1:0] tr);
      int unsigned n = 0;
      hsel = 1'b1; htrans = tr; hwrite = w; hexcl = ex; haddr = a; hsize = sz;
      do begin
         @(negedge clk);
         n++;
      end while (!hready_resp && n < 40);
      chk("accept", hready_resp, 1);
      @(posedge clk);
      #1;
      hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0; hexcl = 1'b0; haddr = '0; hsize = '0;
      hwdata = w ? wd : 32'h0;
   endtask

   task automatic issue(input logic w, input logic ex, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [1:0] tr);
      sb.push_back(model(w, ex, a, sz, wd));
      addr_phase(w, ex, a, sz, wd, tr);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      issue(1'b1, 1'b0, a, 3'd2, d, T_NSEQ);
   endtask

   task automatic rd(input logic [31:0] a);
      issue(1'b0, 1'b0, a, 3'd2, 32'h0, T_NSEQ);
   endtask

   task automatic drain;
      int unsigned n = 0;
      while ((dphase || sb.size() != 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic bus_noise(input int unsigned n, input logic sel, input logic [1:0] tr);
      hsel = sel; htrans = tr; haddr = 32'h10; hwrite = 1'b1; hwdata = 32'hFFFF_FFFF; hsize = 3'd2;
      repeat (n) @(posedge clk);
      #1;
      hsel = 1'b0; htrans = T_IDLE; haddr = '0; hwrite = 1'b0; hwdata = '0; hsize = '0;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset", {hready_resp, hresp, hexokay, hrdata}, {1'b1, 1'b0, 1'b0, 32'h0});
         dphase = 1'b0; wcnt = 0; resp_or = 1'b0; resp_and = 1'b1; exok_or = 1'b0;
         sb.delete();
      end else if (dphase) begin
         if (!hready_resp) begin
            wcnt++;
            resp_or  |= hresp;
            resp_and &= hresp;
            exok_or  |= hexokay;
         end else if (sb.size() == 0) begin
            chk("sb_size", sb.size(), 1);
         end else begin
            cur     = sb.pop_front();
            wait_ok = (wcnt == 0) || (cur.err ? resp_and : !resp_or);
            chk("hresp", hresp, cur.err);
            chk("hexokay", hexokay, cur.exok);
            chk("hrdata", hrdata, cur.rdata);
            chk("waits", wcnt, cur.waits);
            chk("wait_hresp", wait_ok, 1);
            chk("wait_hexokay", exok_or, 0);
            wcnt = 0; resp_or = 1'b0; resp_and = 1'b1; exok_or = 1'b0;
         end
      end else begin
         chk("idle", {hready_resp, hresp, hexokay, hrdata}, {1'b1, 1'b0, 1'b0, 32'h0});
      end
      if (rst_n && hready_resp) dphase = hsel && htrans[1];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // byte and halfword lanes, pipelined write-then-read
      wr(32'h10, 32'h1234_5678);
      issue(1'b1, 1'b0, 32'h11, 3'd0, 32'h0000_AB00, T_NSEQ);
      rd(32'h10);
      wr(32'h14, 32'hFFFF_FFFF);
      issue(1'b1, 1'b0, 32'h16, 3'd1, 32'h5A5A_0000, T_NSEQ);
      issue(1'b1, 1'b0, 32'h14, 3'd0, 32'h0000_00C3, T_NSEQ);
      rd(32'h14);

      // back-to-back NSEQ+SEQ reads with wait states
      wr(32'h0, 32'h0BAD_F00D);
      wr(32'h4, 32'h0000_0404);
      rd(32'h0);
      issue(1'b0, 1'b0, 32'h4, 3'd2, 32'h0, T_SEQ);

      // exclusive monitor
      wr(32'h40, 32'h0);
      wr(32'h48, 32'h4848_4848);
      wr(32'h50, 32'h5050_5050);
      issue(1'b0, 1'b1, 32'h40, 3'd2, 32'h0, T_NSEQ);
      issue(1'b1, 1'b1, 32'h40, 3'd2, 32'h0000_DEAD, T_NSEQ);
      rd(32'h40);
      issue(1'b0, 1'b1, 32'h40, 3'd2, 32'h0, T_NSEQ);
      wr(32'h40, 32'h1);
      issue(1'b1, 1'b1, 32'h40, 3'd2, 32'h2, T_NSEQ);
      rd(32'h40);
      issue(1'b1, 1'b1, 32'h40, 3'd2, 32'h3, T_NSEQ);
      issue(1'b0, 1'b1, 32'h40, 3'd2, 32'h0, T_NSEQ);
      wr(32'h44, 32'h7);
      issue(1'b1, 1'b1, 32'h40, 3'd2, 32'h55, T_NSEQ);
      issue(1'b0, 1'b1, 32'h40, 3'd2, 32'h0, T_NSEQ);
      issue(1'b0, 1'b1, 32'h48, 3'd2, 32'h0, T_NSEQ);
      issue(1'b1, 1'b1, 32'h40, 3'd2, 32'h66, T_NSEQ);
      issue(1'b1, 1'b1, 32'h48, 3'd2, 32'h77, T_NSEQ);
      rd(32'h40);
      rd(32'h48);

      // out of range: ERROR, no write, no aliasing, reservation untouched
      issue(1'b0, 1'b1, 32'h50, 3'd2, 32'h0, T_NSEQ);
      issue(1'b0, 1'b1, 32'h1000, 3'd2, 32'h0, T_NSEQ);
      rd(32'h2000);
      wr(32'h1000, 32'hEEEE_EEEE);
      wr(32'h8000_0010, 32'hEEEE_EEEE);
      issue(1'b1, 1'b1, 32'h50, 3'd2, 32'h88, T_NSEQ);
      rd(32'h0);
      rd(32'h10);
      rd(32'h50);
      drain();

      // BUSY, IDLE and unselected cycles change nothing
      bus_noise(3, 1'b1, T_BUSY);
      bus_noise(3, 1'b0, T_NSEQ);
      bus_noise(2, 1'b1, T_IDLE);
      rd(32'h10);

      // randomised mix over a small window
      for (int unsigned k = 0; k < 8; k++) wr(32'h100 + 4 * k, $urandom);
      for (int unsigned k = 0; k < 40; k++) begin
         logic [31:0] a;
         logic [2:0]  sz;
         logic [1:0]  op;
         sz = 3'($urandom_range(0, 2));
         a  = 32'h100 + 4 * $urandom_range(0, 7) + ($urandom_range(0, 3) & ~((32'd1 << sz) - 1));
         op = 2'($urandom_range(0, 3));
         issue(op[0], op[1], a, sz, $urandom, T_NSEQ);
      end
      drain();

      // reset in the first wait cycle of a write abandons it and drops the reservation
      wr(32'h8, 32'hCAFE_F00D);
      issue(1'b0, 1'b1, 32'h8, 3'd2, 32'h0, T_NSEQ);
      addr_phase(1'b1, 1'b0, 32'h8, 3'd2, 32'h1111_1111, T_NSEQ);
      rst_n   = 1'b0;
      ref_vld = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(1'b1, 1'b1, 32'h8, 3'd2, 32'h2222_2222, T_NSEQ);
      rd(32'h8);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
